// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, requester count and lock FSM encoding for the RAM port arbiter.
package ram_port_arbiter_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } lock_state_e;

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: requests, write data, grants, read data, contention counter.
interface ram_port_arbiter_if;
    import ram_port_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      conflict_clr;
    logic [15:0]               conflict_cnt;

    modport master (
        output req, we, lock, addr, wdata, conflict_clr,
        input  gnt, rvalid, rdata, conflict_cnt
    );

    modport slave (
        input  req, we, lock, addr, wdata, conflict_clr,
        output gnt, rvalid, rdata, conflict_cnt
    );

endinterface

// File: rtl/Mem256x16.sv
// 256x16 single-clock RAM with separate read/write ports, registered read and a read-valid flag.
module Mem256x16
    import ram_port_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_valid_out
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_valid;

    // Storage array and registered read; contents are never reset so they survive rst_n.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    // Read-valid flag follows a read enable by one cycle; reset drops an in-flight read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_rd_en;
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_valid_out = r_valid;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a shared 256x16 RAM: round-robin grant, lock for read-modify-write
// with a bounded lock time, one-cycle read latency and a saturating contention counter.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);

    localparam logic [7:0] TIMER_LAST = 8'(LOCK_MAX - 1);

    lock_state_e        r_state, w_state_next;
    logic               r_last, w_last_next;
    logic [7:0]         r_timer, w_timer_next;
    logic               r_owner;
    logic [DATA_W-1:0]  r_rdata_hold;
    logic [15:0]        r_conflict_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_acc;
    logic [NUM_REQ-1:0] w_rvalid;
    logic               w_acc_valid;
    logic               w_acc_id;
    logic               w_acc_we;
    logic               w_locked_id;
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
    logic               w_mem_valid;
    logic [DATA_W-1:0]  w_mem_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
            assign w_rvalid[gi]    = w_mem_valid && (r_owner == 1'(gi));
        end
    endgenerate

    assign w_acc       = bus.req & w_gnt;
    assign w_acc_valid = |w_acc;
    assign w_acc_id    = w_acc[1];
    assign w_acc_we    = bus.we[w_acc_id];
    assign w_locked_id = (r_state == ST_LOCKED1);

    // Grant: round-robin when unlocked, only the lock holder while locked, nothing in reset.
    always_comb begin
        w_gnt = '0;
        if (rst_n) begin
            case (r_state)
                ST_UNLOCKED: w_gnt = (bus.req == 2'b11) ? req_onehot(~r_last) : bus.req;
                ST_LOCKED0,
                ST_LOCKED1:  w_gnt = bus.req & req_onehot(w_locked_id);
                default:     w_gnt = '0;
            endcase
        end
    end

    // Lock FSM next state, round-robin pointer and lock timer.
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_timer_next = r_timer;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_acc_valid) begin
                    w_last_next = w_acc_id;
                    if (bus.lock[w_acc_id]) begin
                        w_state_next = w_acc_id ? ST_LOCKED1 : ST_LOCKED0;
                        w_timer_next = 8'd0;
                    end
                end
            end
            ST_LOCKED0,
            ST_LOCKED1: begin
                if (r_timer == TIMER_LAST) begin
                    // Lock held too long: release and let the other requester win next contention.
                    w_state_next = ST_UNLOCKED;
                    w_last_next  = w_locked_id;
                    w_timer_next = 8'd0;
                end else if (w_acc_valid) begin
                    w_last_next = w_locked_id;
                    if (!bus.lock[w_locked_id]) begin
                        w_state_next = ST_UNLOCKED;
                        w_timer_next = 8'd0;
                    end else begin
                        w_timer_next = r_timer + 8'd1;
                    end
                end else if (!bus.req[w_locked_id]) begin
                    w_state_next = ST_UNLOCKED;
                    w_timer_next = 8'd0;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
                w_timer_next = 8'd0;
            end
        endcase
    end

    // Lock FSM state register; reset points the round-robin so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNLOCKED;
            r_last  <= 1'b1;
            r_timer <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_timer <= w_timer_next;
        end
    end

    // Remember which requester issued the read that is currently in the RAM pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
        end else if (w_acc_valid && !w_acc_we) begin
            r_owner <= w_acc_id;
        end
    end

    // Hold the last returned read word so rdata stays stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_hold <= '0;
        end else if (w_mem_valid) begin
            r_rdata_hold <= w_mem_rdata;
        end
    end

    // Saturating count of cycles where both requesters ask; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= 16'd0;
        end else if (bus.conflict_clr) begin
            r_conflict_cnt <= 16'd0;
        end else if (bus.req == 2'b11 && r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    Mem256x16 u_mem (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (w_acc_valid && w_acc_we),
        .i_wr_addr   (w_addr_arr[w_acc_id]),
        .i_wr_data   (w_wdata_arr[w_acc_id]),
        .i_rd_en     (w_acc_valid && !w_acc_we),
        .i_rd_addr   (w_addr_arr[w_acc_id]),
        .o_rd_data   (w_mem_rdata),
        .o_valid_out (w_mem_valid)
    );

    assign bus.gnt          = w_gnt;
    assign bus.rvalid       = w_rvalid;
    assign bus.rdata        = w_mem_valid ? w_mem_rdata : r_rdata_hold;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic against a
// behavioural model of grant, lock, memory, read pipeline and contention counter.
module tb_ram_port_arbiter;

    localparam int LOCK_MAX = 16;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    ram_port_arbiter_if bus();

    ram_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_owner = -1;      // lock holder, -1 when free
    int          m_timer = 0;       // locked cycles completed
    int          m_last = 1;        // last accepted requester
    int          m_pend = -1;       // requester whose read returns this cycle
    logic [15:0] m_pend_data = 16'h0;
    bit          m_pend_known = 1'b0;
    logic [15:0] m_rdata = 16'h0;
    bit          m_rdata_known = 1'b1;
    int          m_cnt = 0;
    logic [15:0] mem_val [256];
    bit          mem_known [256];

    function automatic logic [1:0] exp_gnt();
        if (!rst_n) return 2'b00;
        if (m_owner >= 0) return bus.req[m_owner] ? 2'(1 << m_owner) : 2'b00;
        if (bus.req == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
        return bus.req;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    always @(posedge clk) begin : model
        logic [1:0] g;
        int k;
        int a;
        if (!rst_n) begin
            m_owner = -1; m_timer = 0; m_last = 1; m_pend = -1;
            m_rdata = 16'h0; m_rdata_known = 1'b1; m_cnt = 0;
        end else begin
            g = exp_gnt();
            k = -1;
            if (g[0] && bus.req[0]) k = 0;
            else if (g[1] && bus.req[1]) k = 1;
            if (bus.conflict_clr) m_cnt = 0;
            else if (bus.req == 2'b11 && m_cnt < 65535) m_cnt++;
            if (m_pend >= 0) begin
                m_rdata = m_pend_data;
                m_rdata_known = m_pend_known;
            end
            m_pend = -1;
            if (k >= 0) begin
                a = (k == 1) ? int'(bus.addr[15:8]) : int'(bus.addr[7:0]);
                if (bus.we[k]) begin
                    mem_val[a]   = (k == 1) ? bus.wdata[31:16] : bus.wdata[15:0];
                    mem_known[a] = 1'b1;
                end else begin
                    m_pend       = k;
                    m_pend_data  = mem_val[a];
                    m_pend_known = mem_known[a];
                end
            end
            if (m_owner < 0) begin
                if (k >= 0) begin
                    m_last = k;
                    if (bus.lock[k]) begin
                        m_owner = k;
                        m_timer = 0;
                    end
                end
            end else if (m_timer + 1 >= LOCK_MAX) begin
                m_last = m_owner;
                m_owner = -1;
            end else if (k == m_owner) begin
                m_last = k;
                if (!bus.lock[k]) m_owner = -1;
                else m_timer++;
            end else if (!bus.req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_timer++;
            end
        end
    end

    // Per-cycle compare of every output against the model, mid-cycle.
    always @(negedge clk) begin : compare
        logic [1:0]  ev;
        logic [15:0] er;
        bit          ek;
        ev = 2'b00; er = 16'h0; ek = 1'b1;
        if (rst_n && m_pend >= 0) begin
            ev = (m_pend == 1) ? 2'b10 : 2'b01;
            er = m_pend_data;
            ek = m_pend_known;
        end else if (rst_n) begin
            er = m_rdata;
            ek = m_rdata_known;
        end
        check("gnt", 16'(bus.gnt), 16'(exp_gnt()));
        check("rvalid", 16'(bus.rvalid), 16'(ev));
        if (ek) check("rdata", bus.rdata, er);
        check("conflict_cnt", bus.conflict_cnt, rst_n ? 16'(m_cnt) : 16'h0);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] lk,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1, input logic clr);
        @(posedge clk);
        #1;
        bus.req = rq; bus.we = wr; bus.lock = lk;
        bus.addr = {a1, a0}; bus.wdata = {d1, d0}; bus.conflict_clr = clr;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : stim
        int n01;
        bit done;
        rst_n = 1'b1;
        bus.req = 2'b00; bus.we = 2'b00; bus.lock = 2'b00;
        bus.addr = '0; bus.wdata = '0; bus.conflict_clr = 1'b0;
        #1 rst_n = 1'b0;

        // Grant stays zero while in reset even with both requesting.
        @(posedge clk);
        #1 bus.req = 2'b11;
        #3 check("reset_gnt", 16'(bus.gnt), 16'h0);
        check("reset_cnt", bus.conflict_cnt, 16'h0);
        check("reset_rvalid", 16'(bus.rvalid), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; bus.req = 2'b00;

        // Round-robin under contention from reset.
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1'b0); #3 check("rr_gnt0", 16'(bus.gnt), 16'h1);
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1'b0); #3 check("rr_gnt1", 16'(bus.gnt), 16'h2);
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1'b0); #3 check("rr_gnt2", 16'(bus.gnt), 16'h1);
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1'b0); #3 check("rr_gnt3", 16'(bus.gnt), 16'h2);
        idle(); #3 check("rr_cnt", bus.conflict_cnt, 16'd4);

        // Write by requester 0 then read back by requester 1.
        drive(2'b01, 2'b01, 2'b00, 8'h05, 8'h00, 16'h1234, 16'h0, 1'b0); #3 check("wr_gnt", 16'(bus.gnt), 16'h1);
        drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 16'h0, 16'h0, 1'b0); #3 check("rd_gnt", 16'(bus.gnt), 16'h2);
        idle(); #3 check("rd_rvalid", 16'(bus.rvalid), 16'h2);
        check("rd_rdata", bus.rdata, 16'h1234);

        // Reset the cycle after a read is accepted: read is dropped, memory survives.
        drive(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0; bus.req = 2'b11;
        #3 check("rst_rvalid", 16'(bus.rvalid), 16'h0);
        check("rst_gnt", 16'(bus.gnt), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; bus.req = 2'b00;
        #3 check("post_rst_rvalid", 16'(bus.rvalid), 16'h0);
        drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 16'h0, 16'h0, 1'b0); #3 check("keep_gnt", 16'(bus.gnt), 16'h2);
        idle(); #3 check("keep_rvalid", 16'(bus.rvalid), 16'h2);
        check("keep_rdata", bus.rdata, 16'h1234);

        // Locked read-modify-write by requester 0 while requester 1 waits.
        drive(2'b11, 2'b00, 2'b01, 8'h10, 8'h11, 16'h0, 16'h0, 1'b0); #3 check("rmw_gnt_rd", 16'(bus.gnt), 16'h1);
        drive(2'b11, 2'b01, 2'b00, 8'h10, 8'h11, 16'hBEEF, 16'h0, 1'b0); #3 check("rmw_gnt_wr", 16'(bus.gnt), 16'h1);
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0, 1'b0); #3 check("rmw_gnt_rel", 16'(bus.gnt), 16'h2);
        idle(); #3 check("rmw_rdata", bus.rdata, 16'hBEEF);

        // Lock held continuously: released after LOCK_MAX locked cycles.
        drive(2'b11, 2'b00, 2'b01, 8'h20, 8'h21, 16'h0, 16'h0, 1'b0); #3 check("lock_entry_gnt", 16'(bus.gnt), 16'h1);
        n01 = 0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            drive(2'b11, 2'b00, 2'b01, 8'h20, 8'h21, 16'h0, 16'h0, 1'b0);
            #3;
            if (bus.gnt == 2'b01) n01++;
            else done = 1'b1;
        end
        check("lock_expiry_cycles", 16'(n01), 16'(LOCK_MAX));
        check("lock_expiry_gnt", 16'(bus.gnt), 16'h2);
        idle();

        // Counter saturation and clear priority.
        drive(2'b11, 2'b00, 2'b00, 8'h30, 8'h31, 16'h0, 16'h0, 1'b0);
        repeat (65540) @(posedge clk);
        #4 check("sat_cnt", bus.conflict_cnt, 16'hFFFF);
        drive(2'b11, 2'b00, 2'b00, 8'h30, 8'h31, 16'h0, 16'h0, 1'b1); #3 check("sat_hold", bus.conflict_cnt, 16'hFFFF);
        drive(2'b00, 2'b00, 2'b00, 8'h30, 8'h31, 16'h0, 16'h0, 1'b0); #3 check("clr_cnt", bus.conflict_cnt, 16'h0);

        // Fill memory so every later read has a known expected value.
        for (int i = 0; i < 256; i++) begin
            drive(2'b01, 2'b01, 2'b00, 8'(i), 8'h00, 16'($urandom), 16'h0, 1'b0);
        end

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            drive(2'($urandom), 2'($urandom),
                  {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 31) == 0));
        end
        idle();
        idle();
        @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 16, max consecutive cycles one requester may hold a lock (range 1..255).
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: req  in  2  per-requester access request, bit k = requester k.
REQ-005 Port: we  in  2  per-requester write enable, 1 = write, 0 = read; valid with req.
REQ-006 Port: lock  in  2  per-requester lock, 1 = keep grant for next access (read-modify-write).
REQ-007 Port: addr  in  16  packed {addr1[7:0], addr0[7:0]}.
REQ-008 Port: wdata  in  32  packed {wdata1[15:0], wdata0[15:0]}.
REQ-009 Port: gnt  out  2  one-hot-or-zero grant, combinational, same cycle as req.
REQ-010 Port: rvalid  out  2  per-requester read-data-valid pulse.
REQ-011 Port: rdata  out  16  read data, shared by both requesters, qualified by rvalid.
REQ-012 Port: conflict_clr  in  1  synchronous clear of conflict_cnt.
REQ-013 Port: conflict_cnt  out  16  saturating count of contention cycles.

Function
REQ-014 Access accepted on a rising edge where req[k]&gnt[k]=1; at most one access per cycle.
REQ-015 Grant: unlocked state -> single requester wins; both requesting -> requester not last accepted wins.
REQ-016 Round-robin pointer updates only on an accepted access; idle cycles leave it unchanged.
REQ-017 FSM states UNLOCKED, LOCKED0, LOCKED1; in LOCKEDk only requester k is granted, even if k idle.
REQ-018 UNLOCKED->LOCKEDk when access by k accepted with lock[k]=1.
REQ-019 LOCKEDk->UNLOCKED when access by k accepted with lock[k]=0, or req[k]=0 for one cycle, or lock timer expires.
REQ-020 Lock timer counts cycles in LOCKEDk, cleared on entry; at LOCK_MAX cycles FSM forced to UNLOCKED and pointer set so requester 1-k wins next contention.
REQ-021 Write: wdata of the granted requester stored at addr on the accepting edge; reads accepted on later edges return new data.
REQ-022 Read latency exactly 1 cycle: rvalid[k]=1 for one cycle following acceptance, rdata = mem[addr] in that cycle.
REQ-023 rvalid never has both bits set; rdata holds last read value when rvalid=0.
REQ-024 Back-to-back reads give one rvalid per cycle, order preserved.
REQ-025 conflict_cnt increments in each cycle with req=2'b11, saturates at 16'hFFFF; conflict_clr has priority over increment.
REQ-026 Memory contents undefined until written; no reset of contents.

Reset
REQ-027 rst_n low asynchronously forces gnt-related state to UNLOCKED, pointer so requester 0 wins first contention, lock timer 0, rvalid 0, rdata 0, conflict_cnt 0.
REQ-028 gnt=0 while rst_n low regardless of req.
REQ-029 Reset during a pending read drops it: no rvalid after reset release.
REQ-030 Writes accepted before reset remain in memory.

Structure
REQ-031 Shared package holds ADDR_W=8, DATA_W=16, NUM_REQ=2 and the lock FSM state enum.
REQ-032 Storage is one instance of existing Mem256x16 (registered read, separate read/write ports); rd_en/wr_en driven from the accepted access, its valid_out plus a 1-bit owner register produce rvalid.

Verification
REQ-033 Write 0x1234 to 0x05 by req0, read 0x05 by req1 next cycle -> rvalid=2'b10 one cycle later, rdata=0x1234.
REQ-034 After reset, req=2'b11 reads for 4 cycles -> grants 01,10,01,10; conflict_cnt=4.
REQ-035 req0 locked read 0x10 then write 0x10 while req1 requests -> gnt stays 01 both cycles, then 10.
REQ-036 req0 holds lock=1, req1 requesting, LOCK_MAX=16 -> gnt switches to 10 after 16 locked cycles.
REQ-037 conflict_cnt preloaded to 0xFFFF by contention -> stays 0xFFFF; conflict_clr with req=11 -> 0.
REQ-038 rst_n pulsed low the cycle after a read is accepted -> rvalid stays 0, gnt=0 during reset.
